// File: rtl/fft_out_serializer.sv
// Parallel-to-serial converter for the final stage of an 8-point FFT. It captures one
// bit-reversed frame and streams it out in natural frequency order over a valid/ready handshake.
module fft_out_serializer #(
  parameter int unsigned N = 3,
  localparam int unsigned W = 2 ** N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_0_r,
  input  logic [W-1:0] in_1_r,
  input  logic [W-1:0] in_2_r,
  input  logic [W-1:0] in_3_r,
  input  logic [W-1:0] in_4_r,
  input  logic [W-1:0] in_5_r,
  input  logic [W-1:0] in_6_r,
  input  logic [W-1:0] in_7_r,
  input  logic [W-1:0] in_0_i,
  input  logic [W-1:0] in_1_i,
  input  logic [W-1:0] in_2_i,
  input  logic [W-1:0] in_3_i,
  input  logic [W-1:0] in_4_i,
  input  logic [W-1:0] in_5_i,
  input  logic [W-1:0] in_6_i,
  input  logic [W-1:0] in_7_i,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_r,
  output logic [W-1:0] out_i,
  output logic [2:0]   out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e       state_q;
  logic [W-1:0] buf_r_q [8];
  logic [W-1:0] buf_i_q [8];
  logic [W-1:0] in_r    [8];
  logic [W-1:0] in_i    [8];
  logic [2:0]   m_q, m_d;
  logic [W-1:0] out_r_q, out_i_q;
  logic         in_ready_q, out_valid_q, out_last_q;

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  assign in_r[0] = in_0_r;
  assign in_r[1] = in_1_r;
  assign in_r[2] = in_2_r;
  assign in_r[3] = in_3_r;
  assign in_r[4] = in_4_r;
  assign in_r[5] = in_5_r;
  assign in_r[6] = in_6_r;
  assign in_r[7] = in_7_r;
  assign in_i[0] = in_0_i;
  assign in_i[1] = in_1_i;
  assign in_i[2] = in_2_i;
  assign in_i[3] = in_3_i;
  assign in_i[4] = in_4_i;
  assign in_i[5] = in_5_i;
  assign in_i[6] = in_6_i;
  assign in_i[7] = in_7_i;

  assign m_d = m_q + 3'd1;

  // in_ready is registered so it stays low during reset and rises on the first edge after it;
  // capture is gated on it so a frame is never taken in that reset-release cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      m_q         <= 3'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      for (int k = 0; k < 8; k++) begin
        buf_r_q[k] <= '0;
        buf_i_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            for (int k = 0; k < 8; k++) begin
              buf_r_q[k] <= in_r[k];
              buf_i_q[k] <= in_i[k];
            end
            // Sample m=0 lives at entry bitrev(0)=0, so it can be loaded straight from the inputs.
            out_r_q     <= in_r[0];
            out_i_q     <= in_i[0];
            m_q         <= 3'd0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (out_ready) begin
            if (m_q == 3'd7) begin
              m_q         <= 3'd0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= StIdle;
            end else begin
              m_q        <= m_d;
              out_r_q    <= buf_r_q[bitrev3(m_d)];
              out_i_q    <= buf_i_q[bitrev3(m_d)];
              out_last_q <= (m_d == 3'd7);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_idx   = m_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Self-checking bench for fft_out_serializer: directed vector table, hand-written multi-cycle
// sequences (back-to-back, mid-frame reset) and random frames against a reorder model.
`timescale 1ns/1ps
module tb_fft_out_serializer;

  typedef struct packed {
    logic [7:0][7:0] r;
    logic [7:0][7:0] i;
    logic [7:0][7:0] er;
    logic [7:0][7:0] ei;
    logic [1:0]      stall;
    logic [1:0]      mode;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] drv_r [8];
  logic [7:0] drv_i [8];
  logic [7:0] exp_r [8];
  logic [7:0] exp_i [8];
  logic [7:0] nx_r  [8];
  logic [7:0] nx_i  [8];
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_last;
  logic [7:0] out_r, out_i;
  logic [2:0] out_idx;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  vec_t       tbl [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_out_serializer #(.N(3)) dut (
    .clk(clk), .rst(rst),
    .in_0_r(drv_r[0]), .in_1_r(drv_r[1]), .in_2_r(drv_r[2]), .in_3_r(drv_r[3]),
    .in_4_r(drv_r[4]), .in_5_r(drv_r[5]), .in_6_r(drv_r[6]), .in_7_r(drv_r[7]),
    .in_0_i(drv_i[0]), .in_1_i(drv_i[1]), .in_2_i(drv_i[2]), .in_3_i(drv_i[3]),
    .in_4_i(drv_i[4]), .in_5_i(drv_i[5]), .in_6_i(drv_i[6]), .in_7_i(drv_i[7]),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_r(out_r), .out_i(out_i), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Natural index m reads the frame entry whose 3-bit index is m reversed.
  function automatic int brev(input int m);
    return ((m & 1) * 4) + (m & 2) + ((m >> 2) & 1);
  endfunction

  task automatic model_from_drive();
    for (int m = 0; m < 8; m++) begin
      exp_r[m] = drv_r[brev(m)];
      exp_i[m] = drv_i[brev(m)];
    end
  endtask

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < 8; k++) begin
      drv_r[k] = v.r[k];
      drv_i[k] = v.i[k];
      exp_r[k] = v.er[k];
      exp_i[k] = v.ei[k];
    end
  endtask

  task automatic wait_ready();
    int c = 0;
    while (in_ready !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("wait_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Checks one frame beat by beat. mode 0: in_valid low; 1: busy frames with random data;
  // 2: next frame (nx_*) presented with in_valid held high.
  task automatic drain(input int stall, input int mode);
    int m = 0;
    int c = 0;
    bit rdy;
    while (m < 8 && c < 64) begin
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      chk("out_idx", 32'(out_idx), 32'(m));
      chk("out_r", 32'(out_r), 32'(exp_r[m]));
      chk("out_i", 32'(out_i), 32'(exp_i[m]));
      chk("out_last", 32'(out_last), 32'(m == 7));
      if (mode == 0) begin
        in_valid = 1'b0;
      end else if (mode == 1) begin
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
          drv_r[k] = 8'($urandom);
          drv_i[k] = 8'($urandom);
        end
      end else begin
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
          drv_r[k] = nx_r[k];
          drv_i[k] = nx_i[k];
        end
      end
      if (stall == 0) rdy = 1'b1;
      else if (stall == 1) rdy = (c % 3 == 0);
      else rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      if (rdy) m++;
      c++;
    end
    if (m < 8) chk("drain_timeout", 32'(m), 32'd8);
    @(negedge clk);
    chk("bubble_out_valid", 32'(out_valid), 32'd0);
    chk("bubble_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    if (mode != 2) in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    load_vec(v);
    in_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    drain(int'(v.stall), int'(v.mode));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 8; k++) begin
        tbl[j].r[k] = 8'(16 * k + 1);
        tbl[j].i[k] = 8'(-(k + 1));
      end
      tbl[j].er = {8'h71, 8'h31, 8'h51, 8'h11, 8'h61, 8'h21, 8'h41, 8'h01};
      tbl[j].ei = {8'hF8, 8'hFC, 8'hFA, 8'hFE, 8'hF9, 8'hFD, 8'hFB, 8'hFF};
    end
    tbl[0].stall = 2'd0; tbl[0].mode = 2'd0;
    tbl[1].stall = 2'd1; tbl[1].mode = 2'd0;
    tbl[2].stall = 2'd0; tbl[2].mode = 2'd1;
    for (int k = 0; k < 8; k++) begin
      tbl[3].r[k] = (k % 2 == 0) ? 8'h80 : 8'h7F;
      tbl[3].i[k] = (k % 2 == 0) ? 8'h7F : 8'h80;
    end
    tbl[3].er = {8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h80};
    tbl[3].ei = {8'h80, 8'h80, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
    tbl[3].stall = 2'd2; tbl[3].mode = 2'd0;
    for (int k = 0; k < 8; k++) begin
      drv_r[k] = 8'h00;
      drv_i[k] = 8'h00;
    end

    // Reset state, and in_ready after the first edge out of reset.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_r", 32'(out_r), 32'd0);
    chk("rst_out_i", 32'(out_i), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    for (int j = 0; j < 4; j++) run_vec(tbl[j]);

    // Back-to-back: in_valid held high, second frame presented during the first.
    load_vec(tbl[0]);
    for (int k = 0; k < 8; k++) begin
      nx_r[k] = 8'($urandom);
      nx_i[k] = 8'($urandom);
    end
    in_valid = 1'b1;
    wait_ready();
    t0 = cyc;
    @(posedge clk);
    drain(0, 2);
    chk("b2b_period", 32'(cyc - t0), 32'd9);
    model_from_drive();
    @(posedge clk);
    drain(0, 0);

    // Reset after three transfers.
    load_vec(tbl[0]);
    in_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk("pre_rst_idx", 32'(out_idx), 32'(b));
    end
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_idx", 32'(out_idx), 32'd0);
    chk("mid_rst_out_r", 32'(out_r), 32'd0);
    chk("mid_rst_out_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    run_vec(tbl[1]);

    // Random frames with random backpressure.
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 8; k++) begin
        drv_r[k] = 8'($urandom);
        drv_i[k] = 8'($urandom);
      end
      model_from_drive();
      in_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      drain(f % 3, (f % 4 == 3) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
